// File: rtl/lms6_tx_sched_if.sv
// Signal bundle between the LMS6 tx burst scheduler, its two sample sources
// and the downstream tx interleaver. The master side is the scheduler.
interface lms6_tx_sched_if #(
  parameter int LEN_W = 16
);
  // Source handshake: sN_ready is high only in a cycle where the interleaver
  // consumes a slot and sN_valid is high; a sample moves when both are high.
  logic              tx_ready_i;
  logic [23:0]       tx_data_o;
  logic              tx_en;
  logic [1:0]        req;
  logic [LEN_W-1:0]  len0;
  logic [LEN_W-1:0]  len1;
  logic [1:0]        grant;
  logic [23:0]       s0_data;
  logic              s0_valid;
  logic              s0_ready;
  logic [23:0]       s1_data;
  logic              s1_valid;
  logic              s1_ready;
  logic              underflow;
  logic              busy;
  logic [1:0]        state_dbg;

  modport master (
    input  tx_ready_i, req, len0, len1, s0_data, s0_valid, s1_data, s1_valid,
    output tx_data_o, tx_en, grant, s0_ready, s1_ready, underflow, busy, state_dbg
  );

  modport slave (
    output tx_ready_i, req, len0, len1, s0_data, s0_valid, s1_data, s1_valid,
    input  tx_data_o, tx_en, grant, s0_ready, s1_ready, underflow, busy, state_dbg
  );
endinterface

// File: rtl/lms6_tx_sched.sv
// Round-robin burst scheduler sharing the LMS6 tx sample path between two
// sources, with underrun fill, a fixed idle guard gap and the RF tx-enable window.
module lms6_tx_sched #(
  parameter int          LEN_W       = 16,
  parameter int          GAP         = 4,
  parameter logic [23:0] IDLE_SAMPLE = 24'h000000
) (
  input  logic            clk,
  input  logic            rst,
  lms6_tx_sched_if.master bus
);
  localparam int            GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       grant_q, grant_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [23:0]      data_q, data_d;
  logic             en_q, en_d;
  logic             unf_q, unf_d;

  logic             slot;
  logic             pick1;
  logic [LEN_W-1:0] pick_len;
  logic             sel_valid;
  logic [23:0]      sel_data;

  assign slot      = bus.tx_ready_i;
  // ptr_q=1 gives source 1 priority when both request; a lone requester always wins.
  assign pick1     = bus.req[1] & (~bus.req[0] | ptr_q);
  assign pick_len  = pick1 ? bus.len1 : bus.len0;
  assign sel_valid = grant_q[1] ? bus.s1_valid : bus.s0_valid;
  assign sel_data  = grant_q[1] ? bus.s1_data : bus.s0_data;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    data_d  = data_q;
    en_d    = en_q;
    unf_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (slot) data_d = IDLE_SAMPLE;
        if (|bus.req) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          cnt_d   = (pick_len == '0) ? LEN_W'(1) : pick_len;
          ptr_d   = ~pick1;
          en_d    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Burst length counts slots, not delivered samples: an underrun still uses a slot.
        if (slot) begin
          if (sel_valid) begin
            data_d = sel_data;
          end else begin
            data_d = IDLE_SAMPLE;
            unf_d  = 1'b1;
          end
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            grant_d = 2'b00;
            if (GAP > 0) begin
              state_d = S_GAP;
              gcnt_d  = GAP_LOAD;
            end else begin
              state_d = S_IDLE;
              en_d    = 1'b0;
            end
          end
        end
      end
      S_GAP: begin
        if (slot) begin
          data_d = IDLE_SAMPLE;
          gcnt_d = gcnt_q - GW'(1);
          if (gcnt_q == GW'(1)) begin
            state_d = S_IDLE;
            en_d    = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      grant_q <= 2'b00;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      data_q  <= IDLE_SAMPLE;
      en_q    <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      data_q  <= data_d;
      en_q    <= en_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.tx_data_o = data_q;
  assign bus.tx_en     = en_q;
  assign bus.grant     = grant_q;
  assign bus.underflow = unf_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.state_dbg = state_q;
  assign bus.s0_ready  = (state_q == S_RUN) & grant_q[0] & slot & bus.s0_valid;
  assign bus.s1_ready  = (state_q == S_RUN) & grant_q[1] & slot & bus.s1_valid;
endmodule

// File: tb/tb_lms6_tx_sched.sv
// Bench for lms6_tx_sched: a GAP=4 instance and a GAP=0 instance share clock,
// reset and the one-in-two tx_ready strobe; slot outputs are checked against a burst-level model.
module tb_lms6_tx_sched;
  localparam int          LEN_W = 16;
  localparam logic [23:0] IDLE  = 24'h000000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic strobe = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   last_a = 0;
  logic rdy0_a, rdy1_a, rdy0_b, rdy1_b;

  logic [23:0] burst_d [16];
  logic        burst_v [16];
  logic [23:0] exp_q[$];
  logic        exp_en_q[$];
  logic        exp_gnt_q[$];
  logic        exp_unf_q[$];
  logic        exp_rdy_q[$];

  lms6_tx_sched_if #(.LEN_W(LEN_W)) ifa ();
  lms6_tx_sched_if #(.LEN_W(LEN_W)) ifb ();
  assign ifa.tx_ready_i = strobe;
  assign ifb.tx_ready_i = strobe;

  lms6_tx_sched #(.LEN_W(LEN_W), .GAP(4), .IDLE_SAMPLE(IDLE)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  lms6_tx_sched #(.LEN_W(LEN_W), .GAP(0), .IDLE_SAMPLE(IDLE)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // ---------------- clock / reset / strobe ----------------
  always #5 clk = ~clk;
  always @(negedge clk) strobe = ~strobe;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200us");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance to just after the next slot edge, capturing the combinational readies before it.
  task automatic next_slot();
    do begin
      @(negedge clk);
      #1;
    end while (!strobe);
    rdy0_a = ifa.s0_ready;
    rdy1_a = ifa.s1_ready;
    rdy0_b = ifb.s0_ready;
    rdy1_b = ifb.s1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input int src, input logic [23:0] d, input logic v);
    if (src == 0) begin
      ifa.s0_data = d;  ifa.s0_valid = v;
      ifa.s1_data = $urandom; ifa.s1_valid = 1'($urandom_range(0, 1));
    end else begin
      ifa.s1_data = d;  ifa.s1_valid = v;
      ifa.s0_data = $urandom; ifa.s0_valid = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((ifa.busy || ifb.busy) && n < 200) begin
      cyc();
      n++;
    end
    checks++;
    if (ifa.busy !== 1'b0 || ifb.busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy a=%b b=%b after %0d cycles, expected 0", ifa.busy, ifb.busy, n);
    end
  endtask

  // ---------------- reference model ----------------
  // A burst occupies max(len,1) slots carrying the source sample or idle on underrun,
  // then gap idle slots; tx_en drops on the last slot of that window, grant on the last burst slot.
  function automatic void model_burst(input int len, input int gap);
    int n = (len == 0) ? 1 : len;
    for (int k = 0; k < n + gap; k++) begin
      exp_q.push_back((k < n && burst_v[k]) ? burst_d[k] : IDLE);
      exp_unf_q.push_back(k < n && !burst_v[k]);
      exp_rdy_q.push_back(k < n && burst_v[k]);
      exp_gnt_q.push_back(k < n - 1);
      exp_en_q.push_back(k < n + gap - 1);
    end
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    ifa.req = 2'b11; ifb.req = 2'b11;
    ifa.len0 = 1; ifa.len1 = 1; ifb.len0 = 1; ifb.len1 = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (ifa.grant !== 2'b00 || ifa.tx_en !== 1'b0 || ifa.tx_data_o !== IDLE ||
          ifa.busy !== 1'b0 || ifa.underflow !== 1'b0 || ifb.grant !== 2'b00 || ifb.tx_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: grant=%b tx_en=%b data=%h busy=%b unf=%b (b: grant=%b en=%b), expected all zero",
                 ifa.grant, ifa.tx_en, ifa.tx_data_o, ifa.busy, ifa.underflow, ifb.grant, ifb.tx_en);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    cyc();
    checks++;
    if (ifa.grant !== 2'b01 || ifa.tx_en !== 1'b1 || ifb.grant !== 2'b01) begin
      errors++;
      $display("FAIL first_grant: a grant=%b en=%b b grant=%b, expected 01 1 01", ifa.grant, ifa.tx_en, ifb.grant);
    end
    last_a = 0;
    ifa.req = 2'b00; ifb.req = 2'b00;
    wait_idle();
  endtask

  task automatic test_single_burst();
    logic [23:0] ed; logic ee, eg, eu, er;
    burst_d[0] = 24'h111222; burst_d[1] = 24'h333444; burst_d[2] = 24'h555666;
    for (int k = 0; k < 3; k++) burst_v[k] = 1'b1;
    model_burst(3, 4);
    ifa.len0 = 3; ifa.req = 2'b01;
    cyc();
    checks++;
    if (ifa.grant !== 2'b01 || ifa.tx_en !== 1'b1 || ifa.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: grant=%b en=%b busy=%b, expected 01 1 1", ifa.grant, ifa.tx_en, ifa.busy);
    end
    ifa.req = 2'b00; last_a = 0;
    for (int k = 0; k < 7; k++) begin
      drive_a(0, (k < 3) ? burst_d[k] : 24'($urandom), (k < 3) ? 1'b1 : 1'($urandom_range(0, 1)));
      next_slot();
      ed = exp_q.pop_front(); ee = exp_en_q.pop_front(); eg = exp_gnt_q.pop_front();
      eu = exp_unf_q.pop_front(); er = exp_rdy_q.pop_front();
      checks++;
      if ({ifa.tx_data_o, ifa.tx_en, ifa.busy, ifa.grant, ifa.underflow, rdy0_a, rdy1_a} !==
          {ed, ee, ee, (eg ? 2'b01 : 2'b00), eu, er, 1'b0}) begin
        errors++;
        $display("FAIL single_slot %0d: data=%h en=%b busy=%b grant=%b unf=%b rdy=%b%b, expected %h %b %b %b %b %b0",
                 k, ifa.tx_data_o, ifa.tx_en, ifa.busy, ifa.grant, ifa.underflow, rdy0_a, rdy1_a,
                 ed, ee, ee, (eg ? 2'b01 : 2'b00), eu, er);
      end
      cyc();
      checks++;
      if (ifa.tx_data_o !== ed) begin
        errors++;
        $display("FAIL single_hold %0d: data=%h, expected %h held", k, ifa.tx_data_o, ed);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [23:0] ed; logic ee, eg, eu, er;
    int src, n;
    ifa.len0 = 2; ifa.len1 = 2; ifa.req = 2'b11;
    for (int b = 0; b < 4; b++) begin
      src = 1 - last_a;
      n = 0;
      while (ifa.grant === 2'b00 && n < 8) begin
        cyc();
        n++;
      end
      checks++;
      if (ifa.grant !== (src ? 2'b10 : 2'b01) || ifa.tx_en !== 1'b1 || (b > 0 && n != 0)) begin
        errors++;
        $display("FAIL rr_grant %0d: grant=%b en=%b wait=%0d, expected %b 1 with regrant one edge after window",
                 b, ifa.grant, ifa.tx_en, n, (src ? 2'b10 : 2'b01));
      end
      last_a = src;
      if (b == 3) ifa.req = 2'b00;
      for (int k = 0; k < 2; k++) begin
        burst_d[k] = $urandom;
        burst_v[k] = 1'($urandom_range(0, 3) != 0);
      end
      model_burst(2, 4);
      for (int k = 0; k < 6; k++) begin
        drive_a(src, (k < 2) ? burst_d[k] : 24'($urandom), (k < 2) ? burst_v[k] : 1'($urandom_range(0, 1)));
        next_slot();
        ed = exp_q.pop_front(); ee = exp_en_q.pop_front(); eg = exp_gnt_q.pop_front();
        eu = exp_unf_q.pop_front(); er = exp_rdy_q.pop_front();
        checks++;
        if ({ifa.tx_data_o, ifa.tx_en, ifa.grant, ifa.underflow, (src ? rdy1_a : rdy0_a), (src ? rdy0_a : rdy1_a)} !==
            {ed, ee, (eg ? (src ? 2'b10 : 2'b01) : 2'b00), eu, er, 1'b0}) begin
          errors++;
          $display("FAIL rr_slot %0d.%0d: data=%h en=%b grant=%b unf=%b rdy0/1=%b%b, expected %h %b grant_held=%b %b granted_rdy=%b",
                   b, k, ifa.tx_data_o, ifa.tx_en, ifa.grant, ifa.underflow, rdy0_a, rdy1_a, ed, ee, eg, eu, er);
        end
        cyc();
      end
    end
    wait_idle();
  endtask

  task automatic test_underrun();
    logic [23:0] ed; logic ee, eg, eu, er;
    int unf_cnt = 0, rdy_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      burst_d[k] = $urandom | 24'h1;
      burst_v[k] = (k != 1);
    end
    model_burst(4, 4);
    ifa.len1 = 4; ifa.req = 2'b10;
    cyc();
    ifa.req = 2'b00; last_a = 1;
    for (int k = 0; k < 8; k++) begin
      drive_a(1, (k < 4) ? burst_d[k] : 24'($urandom), (k < 4) ? burst_v[k] : 1'b1);
      next_slot();
      ed = exp_q.pop_front(); ee = exp_en_q.pop_front(); eg = exp_gnt_q.pop_front();
      eu = exp_unf_q.pop_front(); er = exp_rdy_q.pop_front();
      unf_cnt += int'(ifa.underflow === 1'b1);
      rdy_cnt += int'(rdy1_a === 1'b1);
      checks++;
      if ({ifa.tx_data_o, ifa.tx_en, ifa.grant, ifa.underflow, rdy1_a, rdy0_a} !==
          {ed, ee, (eg ? 2'b10 : 2'b00), eu, er, 1'b0}) begin
        errors++;
        $display("FAIL underrun_slot %0d: data=%h en=%b grant=%b unf=%b rdy1=%b rdy0=%b, expected %h %b %b %b %b 0",
                 k, ifa.tx_data_o, ifa.tx_en, ifa.grant, ifa.underflow, rdy1_a, rdy0_a,
                 ed, ee, (eg ? 2'b10 : 2'b00), eu, er);
      end
      cyc();
      unf_cnt += int'(ifa.underflow === 1'b1);
    end
    checks++;
    if (unf_cnt != 1 || rdy_cnt != 3) begin
      errors++;
      $display("FAIL underrun_counts: underflow cycles=%0d s1_ready=%0d, expected 1 and 3", unf_cnt, rdy_cnt);
    end
  endtask

  task automatic test_gap0_len0();
    logic [23:0] d0, d1 [2];
    d0 = $urandom | 24'h1;
    ifb.len0 = 0; ifb.req = 2'b01;
    cyc();
    ifb.req = 2'b10; ifb.len1 = 2;
    ifb.s0_data = d0; ifb.s0_valid = 1'b1;
    next_slot();
    checks++;
    if (ifb.tx_data_o !== d0 || ifb.tx_en !== 1'b0 || ifb.grant !== 2'b00 || ifb.busy !== 1'b0 || rdy0_b !== 1'b1) begin
      errors++;
      $display("FAIL len0_slot: data=%h en=%b grant=%b busy=%b rdy0=%b, expected %h 0 00 0 1",
               ifb.tx_data_o, ifb.tx_en, ifb.grant, ifb.busy, rdy0_b, d0);
    end
    cyc();
    checks++;
    if (ifb.grant !== 2'b10 || ifb.tx_en !== 1'b1 || ifb.tx_data_o !== d0) begin
      errors++;
      $display("FAIL gap0_regrant: grant=%b en=%b data=%h, expected 10 1 %h", ifb.grant, ifb.tx_en, ifb.tx_data_o, d0);
    end
    ifb.req = 2'b00;
    for (int k = 0; k < 2; k++) begin
      d1[k] = $urandom;
      ifb.s1_data = d1[k]; ifb.s1_valid = 1'b1;
      next_slot();
      checks++;
      if (ifb.tx_data_o !== d1[k] || ifb.tx_en !== (k == 0) || ifb.grant !== ((k == 0) ? 2'b10 : 2'b00) || rdy1_b !== 1'b1) begin
        errors++;
        $display("FAIL gap0_slot %0d: data=%h en=%b grant=%b rdy1=%b, expected %h %b %b 1",
                 k, ifb.tx_data_o, ifb.tx_en, ifb.grant, rdy1_b, d1[k], (k == 0), ((k == 0) ? 2'b10 : 2'b00));
      end
    end
    ifb.s0_valid = 1'b0; ifb.s1_valid = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    logic [23:0] ed; logic ee, eg, eu, er;
    ifa.len0 = 5; ifa.req = 2'b01;
    cyc();
    drive_a(0, $urandom | 24'h1, 1'b1);
    next_slot();
    drive_a(0, $urandom | 24'h1, 1'b1);
    do @(negedge clk); while (!strobe);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (ifa.grant !== 2'b00 || ifa.tx_en !== 1'b0 || ifa.busy !== 1'b0 || ifa.tx_data_o !== IDLE) begin
      errors++;
      $display("FAIL async_reset: grant=%b en=%b busy=%b data=%h, expected 00 0 0 000000",
               ifa.grant, ifa.tx_en, ifa.busy, ifa.tx_data_o);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      burst_d[k] = $urandom;
      burst_v[k] = 1'b1;
    end
    model_burst(5, 4);
    cyc();
    checks++;
    if (ifa.grant !== 2'b01 || ifa.tx_en !== 1'b1) begin
      errors++;
      $display("FAIL restart_grant: grant=%b en=%b, expected 01 1", ifa.grant, ifa.tx_en);
    end
    ifa.req = 2'b00; last_a = 0;
    for (int k = 0; k < 9; k++) begin
      drive_a(0, (k < 5) ? burst_d[k] : 24'($urandom), (k < 5) ? 1'b1 : 1'b0);
      next_slot();
      ed = exp_q.pop_front(); ee = exp_en_q.pop_front(); eg = exp_gnt_q.pop_front();
      eu = exp_unf_q.pop_front(); er = exp_rdy_q.pop_front();
      checks++;
      if ({ifa.tx_data_o, ifa.tx_en, ifa.busy, ifa.grant, ifa.underflow, rdy0_a} !==
          {ed, ee, ee, (eg ? 2'b01 : 2'b00), eu, er}) begin
        errors++;
        $display("FAIL restart_slot %0d: data=%h en=%b busy=%b grant=%b unf=%b rdy0=%b, expected %h %b %b %b %b %b",
                 k, ifa.tx_data_o, ifa.tx_en, ifa.busy, ifa.grant, ifa.underflow, rdy0_a,
                 ed, ee, ee, (eg ? 2'b01 : 2'b00), eu, er);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    ifa.req = 2'b00; ifa.len0 = '0; ifa.len1 = '0;
    ifa.s0_data = '0; ifa.s0_valid = 1'b0; ifa.s1_data = '0; ifa.s1_valid = 1'b0;
    ifb.req = 2'b00; ifb.len0 = '0; ifb.len1 = '0;
    ifb.s0_data = '0; ifb.s0_valid = 1'b0; ifb.s1_data = '0; ifb.s1_valid = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_underrun();
    test_gap0_len0();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end
endmodule
